// File: rtl/branch_pred_gshare.sv
// Gshare branch predictor: a direct-mapped BTB supplies hit and target, and a PHT of
// 2-bit counters indexed by PC XOR global history supplies the direction.
module branch_pred_gshare #(
   parameter int ADDR_WIDTH  = 64,
   parameter int BTB_ENTRIES = 16,
   parameter int PHT_ENTRIES = 64,
   parameter int GHR_WIDTH   = 6,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic                  i_stall_fetch,
   input  logic [ADDR_WIDTH-1:0] i_pc,
   input  logic                  i_branch_instr,
   input  logic                  i_branch_taken,
   input  logic                  i_mispredict,
   input  logic [ADDR_WIDTH-1:0] i_pc_exec,
   input  logic [ADDR_WIDTH-1:0] i_pc_target_exec,
   input  logic [GHR_WIDTH-1:0]  i_ghr_exec,
   output logic                  o_branch_pred_taken,
   output logic [ADDR_WIDTH-1:0] o_pc_target_pred,
   output logic [GHR_WIDTH-1:0]  o_ghr_snapshot,
   output logic [CNT_WIDTH-1:0]  o_mispred_count
);

   localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
   localparam int PHT_IDX_W = $clog2(PHT_ENTRIES);
   localparam int TAG_W     = ADDR_WIDTH - BTB_IDX_W - 2;

   logic                  btb_valid_q [BTB_ENTRIES];
   logic [TAG_W-1:0]      btb_tag_q   [BTB_ENTRIES];
   logic [ADDR_WIDTH-1:0] btb_tgt_q   [BTB_ENTRIES];
   logic [1:0]            pht_q       [PHT_ENTRIES];

   logic [GHR_WIDTH-1:0]  ghr_q, ghr_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic [BTB_IDX_W-1:0]  fetch_btb_idx, exec_btb_idx;
   logic [TAG_W-1:0]      fetch_tag, exec_tag;
   logic [PHT_IDX_W-1:0]  fetch_pht_idx, exec_pht_idx;
   logic                  btb_hit;
   logic                  pred_taken;
   logic                  repair;
   logic [GHR_WIDTH-1:0]  ghr_spec, ghr_repair;
   logic [1:0]            pht_cur, pht_d;
   logic                  unused_pc_bits;

   assign unused_pc_bits = ^{i_pc[1:0], i_pc_exec[1:0]};

   // Fetch-side lookup
   assign fetch_btb_idx = i_pc[BTB_IDX_W+1:2];
   assign fetch_tag     = i_pc[ADDR_WIDTH-1:BTB_IDX_W+2];
   assign fetch_pht_idx = i_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);

   assign btb_hit    = btb_valid_q[fetch_btb_idx] && (btb_tag_q[fetch_btb_idx] == fetch_tag);
   assign pred_taken = btb_hit && pht_q[fetch_pht_idx][1];

   assign o_branch_pred_taken = pred_taken;
   assign o_pc_target_pred    = btb_tgt_q[fetch_btb_idx];
   assign o_ghr_snapshot      = ghr_q;
   assign o_mispred_count     = cnt_q;

   // Exec-side update addressing
   assign exec_btb_idx = i_pc_exec[BTB_IDX_W+1:2];
   assign exec_tag     = i_pc_exec[ADDR_WIDTH-1:BTB_IDX_W+2];
   assign exec_pht_idx = i_pc_exec[PHT_IDX_W+1:2] ^ PHT_IDX_W'(i_ghr_exec);
   assign repair       = i_branch_instr && i_mispredict;

   generate
      if (GHR_WIDTH > 1) begin : g_ghr_shift
         assign ghr_spec   = {ghr_q[GHR_WIDTH-2:0], pred_taken};
         assign ghr_repair = {i_ghr_exec[GHR_WIDTH-2:0], i_branch_taken};
      end else begin : g_ghr_single
         assign ghr_spec   = pred_taken;
         assign ghr_repair = i_branch_taken;
      end
   endgenerate

   // A resolved mispredict rewrites history from the branch's own snapshot, so it wins
   // over the speculative shift and is not held off by a fetch stall.
   always_comb begin
      ghr_d = ghr_q;
      if (repair) begin
         ghr_d = ghr_repair;
      end else if (!i_stall_fetch && btb_hit) begin
         ghr_d = ghr_spec;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (repair && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      pht_cur = pht_q[exec_pht_idx];
      pht_d   = pht_cur;
      if (i_branch_taken) begin
         if (pht_cur != 2'b11) begin
            pht_d = pht_cur + 2'b01;
         end
      end else if (pht_cur != 2'b00) begin
         pht_d = pht_cur - 2'b01;
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         ghr_q <= '0;
         cnt_q <= '0;
      end else begin
         ghr_q <= ghr_d;
         cnt_q <= cnt_d;
      end
   end

   // Tables are flops so they can be cleared asynchronously; lookups read the old
   // contents in the same cycle as a write.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid_q[i] <= 1'b0;
            btb_tag_q[i]   <= '0;
            btb_tgt_q[i]   <= '0;
         end
         for (int i = 0; i < PHT_ENTRIES; i++) begin
            pht_q[i] <= 2'b01;
         end
      end else if (i_branch_instr) begin
         pht_q[exec_pht_idx] <= pht_d;
         if (i_branch_taken) begin
            btb_valid_q[exec_btb_idx] <= 1'b1;
            btb_tag_q[exec_btb_idx]   <= exec_tag;
            btb_tgt_q[exec_btb_idx]   <= i_pc_target_exec;
         end
      end
   end

endmodule

// File: tb/tb_branch_pred_gshare.sv
// Directed bench for branch_pred_gshare: reset, training, history shift/stall,
// repair priority, counter saturation and asynchronous reset of the statistics.
module tb_branch_pred_gshare;

   localparam int AW = 64;
   localparam int GW = 6;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall;
   logic [AW-1:0] pc;
   logic          br_instr;
   logic          br_taken;
   logic          misp;
   logic [AW-1:0] pc_exec;
   logic [AW-1:0] tgt_exec;
   logic [GW-1:0] ghr_exec;
   logic          pred_taken;
   logic [AW-1:0] pred_tgt;
   logic [GW-1:0] ghr_snap;
   logic [CW-1:0] mis_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_pred_gshare #(
      .ADDR_WIDTH (AW),
      .BTB_ENTRIES(16),
      .PHT_ENTRIES(64),
      .GHR_WIDTH  (GW),
      .CNT_WIDTH  (CW)
   ) dut (
      .i_clk              (clk),
      .i_arst             (rst),
      .i_stall_fetch      (stall),
      .i_pc               (pc),
      .i_branch_instr     (br_instr),
      .i_branch_taken     (br_taken),
      .i_mispredict       (misp),
      .i_pc_exec          (pc_exec),
      .i_pc_target_exec   (tgt_exec),
      .i_ghr_exec         (ghr_exec),
      .o_branch_pred_taken(pred_taken),
      .o_pc_target_pred   (pred_tgt),
      .o_ghr_snapshot     (ghr_snap),
      .o_mispred_count    (mis_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resolve(input logic [AW-1:0] p, input logic [AW-1:0] t,
                          input logic [GW-1:0] g, input logic tk, input logic mp);
      pc_exec  = p;
      tgt_exec = t;
      ghr_exec = g;
      br_taken = tk;
      misp     = mp;
      br_instr = 1'b1;
      tick();
      br_instr = 1'b0;
      misp     = 1'b0;
      br_taken = 1'b0;
      #1;
   endtask

   initial begin
      // Reset held while an update is presented: the update must be discarded.
      rst      = 1'b1;
      stall    = 1'b0;
      pc       = 64'h1000;
      br_instr = 1'b1;
      br_taken = 1'b1;
      misp     = 1'b1;
      pc_exec  = 64'h1000;
      tgt_exec = 64'h2000;
      ghr_exec = 6'b000101;
      #1;
      check("rst_taken", pred_taken, 1'b0);
      check("rst_target", pred_tgt, 64'h0);
      check("rst_ghr", ghr_snap, 6'h0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_cnt_no_upd", mis_cnt, 2'd0);
      br_instr = 1'b0;
      br_taken = 1'b0;
      misp     = 1'b0;
      ghr_exec = '0;
      rst      = 1'b0;
      #1;
      check("post_rst_taken", pred_taken, 1'b0);
      check("post_rst_target", pred_tgt, 64'h0);
      check("post_rst_ghr", ghr_snap, 6'h0);

      // Train 0x1000 -> 0x2000 twice with history frozen.
      stall = 1'b1;
      resolve(64'h1000, 64'h2000, 6'h00, 1'b1, 1'b0);
      resolve(64'h1000, 64'h2000, 6'h00, 1'b1, 1'b0);
      check("train_taken", pred_taken, 1'b1);
      check("train_target", pred_tgt, 64'h2000);
      check("train_ghr_frozen", ghr_snap, 6'h0);
      pc = 64'h1040;
      #1;
      check("tag_miss_taken", pred_taken, 1'b0);
      check("tag_miss_target", pred_tgt, 64'h2000);

      // Speculative history: stall holds it, unstalled hit shifts in the prediction.
      pc = 64'h1000;
      tick();
      check("stall_ghr_hold", ghr_snap, 6'h00);
      stall = 1'b0;
      tick();
      check("spec_ghr_shift", ghr_snap, 6'h01);
      stall = 1'b1;
      #1;
      check("ghr1_taken", pred_taken, 1'b0);
      check("ghr1_target", pred_tgt, 64'h2000);

      // Fetch hit and mispredict repair in the same cycle; repair wins.
      stall = 1'b0;
      resolve(64'h3000, 64'h9999, 6'b000101, 1'b0, 1'b1);
      stall = 1'b1;
      #1;
      check("repair_ghr", ghr_snap, 6'b001010);
      check("repair_cnt", mis_cnt, 2'd1);
      check("nt_btb_unchanged", pred_tgt, 64'h2000);

      // Saturate one PHT counter (index 4 ^ 0x0A = 0x0E) and walk it back down.
      pc = 64'h1010;
      for (int i = 0; i < 5; i++) begin
         resolve(64'h1010, 64'h4000, 6'h0A, 1'b1, 1'b0);
      end
      check("sat_taken", pred_taken, 1'b1);
      check("sat_target", pred_tgt, 64'h4000);
      resolve(64'h1010, 64'h4000, 6'h0A, 1'b0, 1'b0);
      check("dec1_taken", pred_taken, 1'b1);
      resolve(64'h1010, 64'h4000, 6'h0A, 1'b0, 1'b0);
      check("dec2_taken", pred_taken, 1'b0);

      // Mispredict counter: ignored without branch_instr, saturates at 3.
      misp = 1'b1;
      tick();
      misp = 1'b0;
      check("misp_no_instr", mis_cnt, 2'd1);
      resolve(64'h2000, 64'h0, 6'h00, 1'b0, 1'b1);
      check("cnt_2", mis_cnt, 2'd2);
      resolve(64'h2000, 64'h0, 6'h00, 1'b0, 1'b1);
      check("cnt_3", mis_cnt, 2'd3);
      resolve(64'h2000, 64'h0, 6'h00, 1'b0, 1'b1);
      check("cnt_sat", mis_cnt, 2'd3);

      // Asynchronous reset between clock edges.
      stall = 1'b0;
      rst   = 1'b1;
      #1;
      check("arst_cnt", mis_cnt, 2'd0);
      check("arst_target", pred_tgt, 64'h0);
      check("arst_taken", pred_taken, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      check("arst_btb_cleared", pred_tgt, 64'h0);
      check("arst_ghr", ghr_snap, 6'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
